// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: groups the requester-side and FIFO-side write signals
// of fifo_wr_arbiter. The arbiter takes the master modport. The producers and
// the FIFO together take the slave modport.
// With ARB_STATS_EN defined, the interface also carries the stall counter.
interface fifo_wr_arbiter_if #(
    parameter int BITS = 32,
    parameter int NREQ = 4
);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0]      req_i;
    logic [NREQ*BITS-1:0] data_i;
    logic [NREQ-1:0]      gnt_o;
    logic                 full_i;
    logic                 push_o;
    logic [BITS-1:0]      data_o;
    logic                 busy_o;
    logic [PW-1:0]        owner_o;
`ifdef ARB_STATS_EN
    logic [15:0]          stall_cnt_o;
`endif

    modport master (
        input  req_i, data_i, full_i,
        output gnt_o, push_o, data_o, busy_o, owner_o
`ifdef ARB_STATS_EN
        , output stall_cnt_o
`endif
    );

    modport slave (
        output req_i, data_i, full_i,
        input  gnt_o, push_o, data_o, busy_o, owner_o
`ifdef ARB_STATS_EN
        , input stall_cnt_o
`endif
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one FIFO write port between NREQ producers.
// Arbitration is round-robin, and each owner's tenure is capped at MAX_BURST
// words. One idle bubble cycle separates consecutive tenures.
// Optional macro ARB_STATS_EN adds a saturating stall-cycle counter.
module fifo_wr_arbiter #(
    parameter int BITS      = 32,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fifo_wr_arbiter_if.master   bus
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            bubble_q, bubble_d;

    logic            selFound;
    logic [PW-1:0]   selIdx;
    logic [PW-1:0]   scanIdx;
    logic            grantEn;
    logic [PW-1:0]   grantIdx;
    logic [BITS-1:0] lanes [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_lane
        assign lanes[k] = bus.data_i[k*BITS +: BITS];
    end

    function automatic logic [PW-1:0] incIdx(input logic [PW-1:0] idx);
        return (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Find the first requesting lane, scanning circularly from the priority pointer.
    always_comb begin
        selFound = 1'b0;
        selIdx   = '0;
        scanIdx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scanIdx = PW'((int'(ptr_q) + i) % NREQ);
            if (!selFound && bus.req_i[scanIdx]) begin
                selFound = 1'b1;
                selIdx   = scanIdx;
            end
        end
    end

    // Grant decision and tenure bookkeeping. A stall holds all state.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        bubble_d = bubble_q;
        grantEn  = 1'b0;
        grantIdx = owner_q;
        case (state_q)
            IDLE: begin
                bubble_d = 1'b0;
                if (!bubble_q && selFound && !bus.full_i) begin
                    grantEn  = 1'b1;
                    grantIdx = selIdx;
                    owner_d  = selIdx;
                    cnt_d    = CW'(1);
                    if (MAX_BURST == 1) begin
                        ptr_d    = incIdx(selIdx);
                        bubble_d = 1'b1;
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                if (!bus.req_i[owner_q] || cnt_q >= CW'(MAX_BURST)) begin
                    state_d  = IDLE;
                    ptr_d    = incIdx(owner_q);
                    bubble_d = 1'b1;
                end else if (!bus.full_i) begin
                    grantEn = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_d == CW'(MAX_BURST)) begin
                        state_d  = IDLE;
                        ptr_d    = incIdx(owner_q);
                        bubble_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drive the FIFO write port. All outputs are forced quiet while reset is asserted.
    always_comb begin
        bus.gnt_o  = '0;
        bus.push_o = 1'b0;
        bus.data_o = '0;
        if (grantEn && !rst_i) begin
            bus.gnt_o[grantIdx] = 1'b1;
            bus.push_o          = 1'b1;
            bus.data_o          = lanes[grantIdx];
        end
    end

    assign bus.busy_o  = !rst_i && (state_q == BURST);
    assign bus.owner_o = rst_i ? '0 : owner_q;

    // Arbiter state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            bubble_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            bubble_q <= bubble_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stall_q;

    // Count the BURST cycles in which the owner still requests but the FIFO is full.
    // The count saturates at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (state_q == BURST && bus.req_i[owner_q] && bus.full_i
                     && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt_o = stall_q;
`endif
endmodule
